// File: rtl/seg7_pattern_reader.sv
// Inverse seven-segment decoder: waits for a stable segment bus, scans one digit per clock,
// publishes nibbles plus blank/error masks. Optional DP capture: SEG7_PATTERN_READER_DP_CAPTURE_EN.
module seg7_pattern_reader #(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET_N,
    input  logic [8*NUM_DIGITS-1:0] SEG_IN,
    input  logic                    START,
    output logic                    BUSY,
    output logic                    VALID,
    output logic [4*NUM_DIGITS-1:0] VALUE,
    output logic [NUM_DIGITS-1:0]   BLANK_MASK,
    output logic [NUM_DIGITS-1:0]   ERR_MASK
`ifdef SEG7_PATTERN_READER_DP_CAPTURE_EN
    ,
    output logic [NUM_DIGITS-1:0]   DP_OUT
`endif
);

    localparam int IW = $clog2(NUM_DIGITS) + 1;
    localparam int SW = $clog2(STABLE_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, SETTLE, SCAN, DONE} state_t;
    state_t state, state_nx;

    logic [NUM_DIGITS-1:0][6:0] seg_c, snap_c;
    logic [NUM_DIGITS-1:0][3:0] nib_w, nib_nx;
    logic [NUM_DIGITS-1:0]      blank_w, blank_nx, err_w, err_nx;
    logic [SW-1:0]              stab_cnt, stab_inc;
    logic [IW-1:0]              idx;
    logic                       stable, stab_done, last_lane;

`ifdef SEG7_PATTERN_READER_DP_CAPTURE_EN
    logic [NUM_DIGITS-1:0] seg_dp, snap_dp, dp_w, dp_nx;
`else
    logic [NUM_DIGITS-1:0] dp_unused;
`endif

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lane
        assign seg_c[k] = SEG_IN[8*k +: 7];
`ifdef SEG7_PATTERN_READER_DP_CAPTURE_EN
        assign seg_dp[k] = SEG_IN[8*k+7];
`else
        assign dp_unused[k] = SEG_IN[8*k+7];
`endif
    end

    // Returns {err, blank, nibble}; codes are gfedcba, active-low.
    function automatic logic [5:0] decode(input logic [6:0] c);
        case (c)
            7'h40: decode = 6'h00;
            7'h79: decode = 6'h01;
            7'h24: decode = 6'h02;
            7'h30: decode = 6'h03;
            7'h19: decode = 6'h04;
            7'h12: decode = 6'h05;
            7'h02: decode = 6'h06;
            7'h78: decode = 6'h07;
            7'h00: decode = 6'h08;
            7'h10: decode = 6'h09;
            7'h08: decode = 6'h0A;
            7'h03: decode = 6'h0B;
            7'h46: decode = 6'h0C;
            7'h21: decode = 6'h0D;
            7'h06: decode = 6'h0E;
            7'h0E: decode = 6'h0F;
            7'h7F: decode = 6'h10;
            default: decode = 6'h20;
        endcase
    endfunction

    assign stab_inc  = stab_cnt + 1'b1;
`ifdef SEG7_PATTERN_READER_DP_CAPTURE_EN
    assign stable    = (seg_c == snap_c) && (seg_dp == snap_dp);
`else
    assign stable    = (seg_c == snap_c);
`endif
    assign stab_done = stable && (stab_inc == SW'(STABLE_CYCLES));
    assign last_lane = (idx == IW'(NUM_DIGITS - 1));
    assign BUSY      = (state != IDLE);
    assign VALID     = (state == DONE);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (START) state_nx = SETTLE;
            SETTLE:  if (stab_done) state_nx = SCAN;
            SCAN:    if (last_lane) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // Merge the lane being scanned into the working words, so the final lane
    // can be committed on the same edge it is decoded.
    always_comb begin
        nib_nx   = nib_w;
        blank_nx = blank_w;
        err_nx   = err_w;
`ifdef SEG7_PATTERN_READER_DP_CAPTURE_EN
        dp_nx    = dp_w;
`endif
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                {err_nx[k], blank_nx[k], nib_nx[k]} = decode(snap_c[k]);
`ifdef SEG7_PATTERN_READER_DP_CAPTURE_EN
                dp_nx[k] = ~snap_dp[k];
`endif
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            snap_c     <= '0;
            stab_cnt   <= '0;
            idx        <= '0;
            nib_w      <= '0;
            blank_w    <= '0;
            err_w      <= '0;
            VALUE      <= '0;
            BLANK_MASK <= '0;
            ERR_MASK   <= '0;
`ifdef SEG7_PATTERN_READER_DP_CAPTURE_EN
            snap_dp    <= '0;
            dp_w       <= '0;
            DP_OUT     <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (START) begin
                    snap_c   <= seg_c;
`ifdef SEG7_PATTERN_READER_DP_CAPTURE_EN
                    snap_dp  <= seg_dp;
`endif
                    stab_cnt <= '0;
                end
                SETTLE: if (stable) begin
                    stab_cnt <= stab_inc;
                    if (stab_done) idx <= '0;
                end else begin
                    snap_c   <= seg_c;
`ifdef SEG7_PATTERN_READER_DP_CAPTURE_EN
                    snap_dp  <= seg_dp;
`endif
                    stab_cnt <= '0;
                end
                SCAN: begin
                    nib_w   <= nib_nx;
                    blank_w <= blank_nx;
                    err_w   <= err_nx;
                    idx     <= idx + 1'b1;
`ifdef SEG7_PATTERN_READER_DP_CAPTURE_EN
                    dp_w    <= dp_nx;
`endif
                    if (last_lane) begin
                        VALUE      <= nib_nx;
                        BLANK_MASK <= blank_nx;
                        ERR_MASK   <= err_nx;
`ifdef SEG7_PATTERN_READER_DP_CAPTURE_EN
                        DP_OUT     <= dp_nx;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_pattern_reader.sv
// Scoreboard bench for seg7_pattern_reader: driver pushes expected results, a negedge monitor
// pops and compares them (including arrival cycle) on every VALID.
module tb_seg7_pattern_reader;

    logic        CLOCK_50 = 1'b0;
    logic        RESET_N  = 1'b0;
    logic [63:0] SEG_IN   = '0;
    logic        START    = 1'b0;
    logic        BUSY, VALID;
    logic [31:0] VALUE;
    logic [7:0]  BLANK_MASK, ERR_MASK;
`ifdef SEG7_PATTERN_READER_DP_CAPTURE_EN
    logic [7:0]  DP_OUT;
`endif

    seg7_pattern_reader dut (
        .CLOCK_50  (CLOCK_50),
        .RESET_N   (RESET_N),
        .SEG_IN    (SEG_IN),
        .START     (START),
        .BUSY      (BUSY),
        .VALID     (VALID),
        .VALUE     (VALUE),
        .BLANK_MASK(BLANK_MASK),
        .ERR_MASK  (ERR_MASK)
`ifdef SEG7_PATTERN_READER_DP_CAPTURE_EN
        ,
        .DP_OUT    (DP_OUT)
`endif
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] val;
        logic [7:0]  blank;
        logic [7:0]  err;
        logic [7:0]  dp;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // Segment codes for hex digits 0..F, gfedcba active-low.
    logic [6:0] seg_code [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [63:0] seg, input int c);
        exp_t m;
        m.val = '0; m.blank = '0; m.err = '0; m.dp = '0; m.cyc = c;
        for (int k = 0; k < 8; k++) begin
            logic [6:0] code;
            logic       hit;
            code = seg[8*k +: 7];
            hit  = 1'b0;
            for (int i = 0; i < 16; i++)
                if (seg_code[i] == code) begin
                    m.val[4*k +: 4] = 4'(i);
                    hit = 1'b1;
                end
            if (code == 7'h7F) m.blank[k] = 1'b1;
            else if (!hit)     m.err[k]   = 1'b1;
            m.dp[k] = ~seg[8*k+7];
        end
        return m;
    endfunction

    function automatic exp_t mk(input logic [31:0] v, input logic [7:0] b, input logic [7:0] e,
                                input logic [7:0] d, input int c);
        exp_t m;
        m.val = v; m.blank = b; m.err = e; m.dp = d; m.cyc = c;
        return m;
    endfunction

    // Monitor: every VALID must match the oldest outstanding expectation.
    always @(negedge CLOCK_50) begin
        if (VALID) begin
            chk("busy_with_valid", 64'(BUSY), 64'd1);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_valid: got VALID with no request outstanding (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("latency",    64'(cyc),        64'(e.cyc));
                chk("value",      64'(VALUE),      64'(e.val));
                chk("blank_mask", 64'(BLANK_MASK), 64'(e.blank));
                chk("err_mask",   64'(ERR_MASK),   64'(e.err));
`ifdef SEG7_PATTERN_READER_DP_CAPTURE_EN
                chk("dp_out",     64'(DP_OUT),     64'(e.dp));
`endif
            end
        end
    end

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || BUSY) && n < 80) begin
            @(negedge CLOCK_50);
            n++;
        end
        checks++;
        if (n >= 80) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, BUSY=%0b", sb.size(), BUSY);
            sb.delete();
        end
    endtask

    // START sampled on the next posedge (cyc+1); VALID expected 12 edges after that.
    task automatic convert(input logic [63:0] seg, input logic use_model, input exp_t e);
        @(negedge CLOCK_50);
        SEG_IN = seg;
        START  = 1'b1;
        if (use_model) sb.push_back(model(seg, cyc + 13));
        else begin
            exp_t x = e;
            x.cyc = cyc + 13;
            sb.push_back(x);
        end
        @(negedge CLOCK_50);
        START = 1'b0;
        wait_drain();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] seg;
        logic [7:0]  lane0;
        int          last;

        // Reset state
        #12;
        chk("rst_busy",  64'(BUSY),       64'd0);
        chk("rst_valid", 64'(VALID),      64'd0);
        chk("rst_value", 64'(VALUE),      64'd0);
        chk("rst_blank", 64'(BLANK_MASK), 64'd0);
        chk("rst_err",   64'(ERR_MASK),   64'd0);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLOCK_50);

        // Directed patterns with spec-given expected words
        convert(64'h78_02_12_19_30_24_79_40, 1'b0, mk(32'h76543210, 8'h00, 8'h00, 8'hFF, 0));
        convert(64'h10_00_0E_06_21_46_03_08, 1'b0, mk(32'h98FEDCBA, 8'h00, 8'h00, 8'hFF, 0));
        convert(64'h7F_40_40_40_55_40_40_40, 1'b0, mk(32'h00000000, 8'h80, 8'h08, 8'hFF, 0));
        convert(64'hC0_C0_C0_C0_C0_40_C0_C0, 1'b0, mk(32'h00000000, 8'h00, 8'h00, 8'h04, 0));

        // Outputs hold between pulses
        repeat (5) @(negedge CLOCK_50);
        chk("hold_value", 64'(VALUE), 64'h0);
        chk("hold_busy",  64'(BUSY),  64'd0);

        // Stability: lane 0 toggles every 2 cycles, plus a START pulse while busy
        seg   = 64'h40_40_40_40_40_40_40_40;
        lane0 = 8'h40;
        @(negedge CLOCK_50);
        SEG_IN = seg;
        START  = 1'b1;
        @(negedge CLOCK_50);
        START = 1'b0;
        last  = cyc;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLOCK_50);
            START = (i == 2);
            @(negedge CLOCK_50);
            START = 1'b0;
            lane0 = (lane0 == 8'h40) ? 8'h79 : 8'h40;
            seg[7:0] = lane0;
            SEG_IN = seg;
            last = cyc;
        end
        sb.push_back(model(seg, last + 13));
        wait_drain();
        chk("stab_nibble0", 64'(VALUE[3:0]), 64'd1);

        // Back-to-back with START held high: one IDLE cycle between conversions
        @(negedge CLOCK_50);
        seg = 64'h0E_06_21_46_03_08_10_00;
        SEG_IN = seg;
        START  = 1'b1;
        sb.push_back(model(seg, cyc + 13));
        sb.push_back(model(seg, cyc + 27));
        repeat (16) @(negedge CLOCK_50);
        START = 1'b0;
        wait_drain();

        // Reset mid-SCAN discards the conversion and clears outputs asynchronously
        @(negedge CLOCK_50);
        SEG_IN = 64'h10_00_0E_06_21_46_03_08;
        START  = 1'b1;
        @(negedge CLOCK_50);
        START = 1'b0;
        repeat (6) @(negedge CLOCK_50);
        #2 RESET_N = 1'b0;
        #1;
        chk("midrst_busy",  64'(BUSY),       64'd0);
        chk("midrst_valid", 64'(VALID),      64'd0);
        chk("midrst_value", 64'(VALUE),      64'd0);
        chk("midrst_blank", 64'(BLANK_MASK), 64'd0);
        chk("midrst_err",   64'(ERR_MASK),   64'd0);
`ifdef SEG7_PATTERN_READER_DP_CAPTURE_EN
        chk("midrst_dp",    64'(DP_OUT),     64'd0);
`endif
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        repeat (20) @(negedge CLOCK_50);
        chk("post_rst_idle", 64'(BUSY), 64'd0);
        convert(64'h78_02_12_19_30_24_79_40, 1'b0, mk(32'h76543210, 8'h00, 8'h00, 8'hFF, 0));

        // Randomized lanes: table codes, blanks, arbitrary codes, random DP
        for (int t = 0; t < 20; t++) begin
            for (int k = 0; k < 8; k++) begin
                logic [6:0] c;
                case ($urandom_range(0, 3))
                    0, 1:    c = seg_code[$urandom_range(0, 15)];
                    2:       c = 7'h7F;
                    default: c = 7'($urandom);
                endcase
                seg[8*k +: 8] = {1'($urandom), c};
            end
            convert(seg, 1'b1, mk(0, 0, 0, 0, 0));
        end

        repeat (20) @(negedge CLOCK_50);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_pattern_reader.md
Name: seg7_pattern_reader

Overview:
- Converts a bank of active-low seven-segment drive patterns back into hex nibbles. It is the inverse of the board's hex-to-segment decoder.
- Used for loopback self-check of HEX0..HEX7 drive logic, and for reading segment buses from external display controllers.
- Per conversion: waits for the input bus to be stable, then scans one digit per clock and publishes a packed value word with per-digit blank/error flags.

Parameters:
- NUM_DIGITS, 8, number of 8-bit digit lanes on SEG_IN (1..8).
- STABLE_CYCLES, 4, consecutive unchanged cycles SEG_IN must hold before scanning (≥1).

Ports:
- CLOCK_50  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- SEG_IN  in  8*NUM_DIGITS  digit k = bits [8k+7:8k]; bit7 = DP, bits 6:0 = g..a; all active-low (0 = lit).
- START  in  1  conversion request, sampled in IDLE only.
- BUSY  out  1  high in every state except IDLE.
- VALID  out  1  one-cycle pulse when results update.
- VALUE  out  4*NUM_DIGITS  nibble k = decoded digit k.
- BLANK_MASK  out  NUM_DIGITS  bit k set = digit k all-off.
- ERR_MASK  out  NUM_DIGITS  bit k set = digit k unrecognised.
- DP_OUT  out  NUM_DIGITS  present only with the optional feature.

Behaviour:
- Reset (async, RESET_N=0):
  - State goes to IDLE immediately.
  - BUSY, VALID, VALUE, BLANK_MASK, ERR_MASK, DP_OUT, snapshot, counters and working registers all clear to 0.
  - Reset mid-conversion discards the conversion; outputs read 0, not prior results.
- Decode table, bits 6:0 hex (gfedcba, active-low). DP is ignored for decode.
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - A=08, b=03, C=46, d=21, E=06, F=0E.
  - 7F = blank: nibble 0, BLANK=1, ERR=0.
  - Any other code: nibble 0, ERR=1, BLANK=0.
- FSM states: IDLE, SETTLE, SCAN, DONE.
- IDLE:
  - BUSY=0.
  - START=1 at an edge: snapshot<=SEG_IN, stab_cnt<=0, go to SETTLE.
- SETTLE:
  - Each edge: if SEG_IN==snapshot, stab_cnt++. Otherwise snapshot<=SEG_IN and stab_cnt<=0.
  - When the increment reaches STABLE_CYCLES: go to SCAN, idx<=0.
  - No timeout; an input that never settles keeps the block in SETTLE until reset.
- SCAN:
  - Each edge decodes snapshot digit idx into working nibble/blank/err bit idx, then idx++.
  - After idx = NUM_DIGITS-1: go to DONE.
  - SEG_IN changes during SCAN are ignored.
- DONE:
  - Working registers are copied to VALUE/BLANK_MASK/ERR_MASK on the edge entering DONE.
  - VALID=1 for exactly this cycle, then go to IDLE.
- Outputs hold their values between VALID pulses.
- Latency: with stable input, VALID is high in cycle STABLE_CYCLES+NUM_DIGITS+1 after the START-sampling edge (13 with defaults).
- START while BUSY=1 is ignored, not queued.
- START held high continuously gives back-to-back conversions, with one IDLE cycle between them.
- VALID and BUSY are never both high except in DONE (BUSY=1 in DONE).
- Counter widths: idx and stab_cnt sized by $clog2 of their limits plus 1. No wrap is reachable.

Optional Feature:
- Macro: SEG7_PATTERN_READER_DP_CAPTURE_EN.
- Defined:
  - DP_OUT port exists.
  - SCAN also records DP_OUT[k] = ~snapshot[8k+7] (1 = DP lit), committed at DONE with the other results.
  - DP_OUT resets to 0.
- Undefined:
  - DP_OUT port is absent.
  - Bit 7 of every lane is fully ignored and no DP register is synthesised.

Test Plan:
- Reset: drive RESET_N=0 mid-SCAN → BUSY, VALID, VALUE, BLANK_MASK and ERR_MASK read 0 asynchronously; after release, START runs a normal conversion.
- Digits: SEG_IN lanes 7..0 = 78,02,12,19,30,24,79,40 held stable, START pulse → VALID at cycle 13, VALUE=0x76543210, ERR_MASK=0x00, BLANK_MASK=0x00.
- Letters: lanes 0..7 = 08,03,46,21,06,0E,00,10 → VALUE=0x98FEDCBA, ERR_MASK=0x00.
- Flags: lane 3 = 55, lane 7 = 7F, other lanes = 40 → ERR_MASK=0x08, BLANK_MASK=0x80, VALUE=0x00000000.
- Stability: toggle lane 0 between 40 and 79 every 2 cycles for 10 cycles after START, then hold 79 → VALID exactly 4+8+1 cycles after the last change, nibble 0 = 1. A START pulse during BUSY → no extra VALID.
- DP (macro defined): lane 2 bit7=0, all other lanes bit7=1 → DP_OUT=0x04. Macro undefined → port absent, VALUE unchanged.
